// File: rtl/uart_receive.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle valid / framing-error strobes.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three rx_s values.
module uart_receive #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD_RT   = 115200,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BAUD_RT;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CW             = $clog2(CYCLES_PER_BIT);
    localparam int unsigned IW             = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 sync1_q, rx_s_q;
    logic                 samp;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] = rx_s one cycle ago, hist_q[1] = two cycles ago; vote lands on the target cycle
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (reset) hist_q <= '1;
        else       hist_q <= {hist_q[0], rx_s_q};
    end

    always_comb begin
        samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
    end
`else
    always_comb begin
        samp = rx_s_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_serial;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CW'(CYCLES_PER_BIT - 1)) begin
                    cnt_d = '0;
                    for (int unsigned i = 0; i + 1 < DATA_BITS; i++) begin
                        sh_d[i] = sh_q[i+1];
                    end
                    sh_d[DATA_BITS-1] = samp;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CW'(CYCLES_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (samp) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at a reduced bit period (100 clocks per bit) to keep runs short.
module tb_uart_receive;

    localparam int CLK   = 1_000_000;
    localparam int BAUD  = 10_000;
    localparam int CPB   = CLK / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;
    localparam int LAT   = 3 + HALF + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_serial = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int st;
    logic prev_pulse = 1'b0;
    logic [7:0] vq[$];
    int         vt[$];
    int         ft[$];

    uart_receive #(.CLK_HZ(CLK), .BAUD_RT(BAUD), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset(reset),
        .rx_serial(rx_serial),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid || rx_frame_err) begin
                check("mutex", 32'(rx_valid & rx_frame_err), 0);
                check("noconsec", 32'(prev_pulse), 0);
            end
            if (rx_valid) begin
                vq.push_back(rx_data);
                vt.push_back(cyc);
            end
            if (rx_frame_err) ft.push_back(cyc);
            prev_pulse = rx_valid | rx_frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic clear_q();
        vq.delete();
        vt.delete();
        ft.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_serial = 1'b1;
        end
    endtask

    // glitch inverts the line for the single cycle at each data bit centre; rst_at pulses reset
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch, input int rst_at);
        for (int c = 0; c < FRAME; c++) begin
            int   bi;
            logic v;
            bi = c / CPB;
            if (bi == 0)       v = 1'b0;
            else if (bi <= DB) v = b[bi-1];
            else               v = stop_v;
            if (glitch && bi >= 1 && bi <= DB && c == HALF + bi * CPB) v = ~v;
            @(negedge clk);
            if (c == 0) st = cyc;
            if (c == rst_at + 1) begin
                check("rst_busy", 32'(rx_busy), 0);
                check("rst_valid", 32'(rx_valid), 0);
                reset = 1'b0;
            end
            if (c == rst_at) reset = 1'b1;
            rx_serial = v;
        end
    endtask

    initial begin
        int s0;
        logic [7:0] exp3[3];
        exp3[0] = 8'h00;
        exp3[1] = 8'hFF;
        exp3[2] = 8'h3C;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data", 32'(rx_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_ferr", 32'(rx_frame_err), 0);
        check("rst_busy", 32'(rx_busy), 0);
        idle(5);

        // single 0xA5 frame and its latency from the pin falling edge
        clear_q();
        send_frame(8'hA5, 1'b1, 1'b0, -10);
        s0 = st;
        idle(2 * CPB);
        check("a5_cnt", vq.size(), 1);
        if (vq.size() > 0) begin
            check("a5_data", 32'(vq[0]), 32'hA5);
            check("a5_lat", vt[0] - s0, LAT);
        end
        check("a5_ferr", ft.size(), 0);

        // three frames with zero idle bits between them
        clear_q();
        send_frame(8'h00, 1'b1, 1'b0, -10);
        s0 = st;
        send_frame(8'hFF, 1'b1, 1'b0, -10);
        send_frame(8'h3C, 1'b1, 1'b0, -10);
        idle(2 * CPB);
        check("b2b_cnt", vq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < vq.size()) check("b2b_data", 32'(vq[i]), 32'(exp3[i]));
        end
        if (vq.size() == 3) begin
            check("b2b_lat0", vt[0] - s0, LAT);
            check("b2b_gap1", vt[1] - vt[0], FRAME);
            check("b2b_gap2", vt[2] - vt[1], FRAME);
        end

        // short low pulse shorter than half a bit is rejected as a glitch start
        clear_q();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) check("gl_busy", 32'(rx_busy), 1);
            rx_serial = 1'b0;
        end
        idle(2 * CPB);
        check("gl_idle", 32'(rx_busy), 0);
        check("gl_valid", vq.size(), 0);
        check("gl_ferr", ft.size(), 0);
        send_frame(8'h55, 1'b1, 1'b0, -10);
        idle(2 * CPB);
        check("gl_cnt55", vq.size(), 1);
        if (vq.size() > 0) check("gl_data55", 32'(vq[0]), 32'h55);

        // stop bit low, then a long break before idling
        clear_q();
        send_frame(8'h81, 1'b0, 1'b0, -10);
        s0 = st;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            rx_serial = 1'b0;
        end
        idle(2 * CPB);
        check("fe_cnt", ft.size(), 1);
        if (ft.size() > 0) check("fe_lat", ft[0] - s0, LAT);
        check("fe_valid", vq.size(), 0);
        check("fe_data", 32'(rx_data), 32'h55);
        check("fe_busy", 32'(rx_busy), 0);
        send_frame(8'h42, 1'b1, 1'b0, -10);
        idle(2 * CPB);
        check("fe_cnt42", vq.size(), 1);
        if (vq.size() > 0) check("fe_data42", 32'(vq[0]), 32'h42);

        // reset pulse in the middle of data bit 4
        clear_q();
        send_frame(8'hF0, 1'b1, 1'b0, HALF + 5 * CPB);
        idle(2 * CPB);
        check("mr_valid", vq.size(), 0);
        check("mr_data", 32'(rx_data), 0);
        send_frame(8'h0F, 1'b1, 1'b0, -10);
        idle(2 * CPB);
        check("mr_cnt0f", vq.size(), 1);
        if (vq.size() > 0) check("mr_data0f", 32'(vq[0]), 32'h0F);

        // one-cycle inversion at every data bit centre
        clear_q();
        send_frame(8'h96, 1'b1, 1'b1, -10);
        idle(2 * CPB);
        check("mj_cnt", vq.size(), 1);
`ifdef UART_RX_MAJORITY_EN
        if (vq.size() > 0) check("mj_data", 32'(vq[0]), 32'h96);
`else
        if (vq.size() > 0) check("mj_data", 32'(vq[0]), 32'h69);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
